// File: rtl/gpu_instruction_issuer.sv
// gpu_instruction_issuer: buffers host sprite commands and issues the
// 35-bit GPU instruction stream, with a built-in 256-word sprite clear.
//
// Ports:
//   Clk, Reset_n          clock, async active-low reset
//   CmdValid/CmdReady     command handshake (CmdReady = FIFO not full)
//   CmdOpcode/Sprite/Data command fields; opcode 0 is dropped
//   ClearReq              single-cycle request for the clear sequence
//   IssueEnable           issue window; nothing but NOP while low
//   Instruction           registered {opcode, sprite, payload}
//   Busy                  clear pending or running
//   ClearDone             one-cycle pulse after the last clear word
//   Count                 FIFO occupancy
module gpu_instruction_issuer #(
    parameter int         DEPTH        = 16,
    parameter logic [3:0] CLEAR_OPCODE = 4'hF
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     CmdValid,
    output logic                     CmdReady,
    input  logic [3:0]               CmdOpcode,
    input  logic [7:0]               CmdSprite,
    input  logic [22:0]              CmdData,
    input  logic                     ClearReq,
    input  logic                     IssueEnable,
    output logic [34:0]              Instruction,
    output logic                     Busy,
    output logic                     ClearDone,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   FULLCOUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } stateT;

    logic [34:0]   fifoMem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    stateT         state;
    logic [7:0]    clearIndex;
    logic          pendingClear;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full     = (Count == FULLCOUNT);
    assign empty    = (Count == '0);
    assign CmdReady = !full;

    // Opcode 0 is handshaked but never stored.
    assign push = CmdValid && !full && (CmdOpcode != 4'h0);

    // A pending clear blocks popping so queued work waits for the clear.
    assign pop = (state == IDLE) && IssueEnable && !empty && !pendingClear;

    always_ff @(posedge Clk) begin
        if (push) begin
            fifoMem[wrPtr] <= {CmdOpcode, CmdSprite, CmdData};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                Count <= Count + 1'b1;
            end else if (pop && !push) begin
                Count <= Count - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            clearIndex   <= '0;
            pendingClear <= 1'b0;
            Busy         <= 1'b0;
            ClearDone    <= 1'b0;
            Instruction  <= '0;
        end else begin
            ClearDone   <= 1'b0;
            Instruction <= '0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        Instruction <= fifoMem[rdPtr];
                    end
                    // The entry cycle into CLEAR issues NOP.
                    if (pendingClear) begin
                        if (IssueEnable) begin
                            state      <= CLEAR;
                            clearIndex <= '0;
                        end
                    end else if (ClearReq) begin
                        pendingClear <= 1'b1;
                        Busy         <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (IssueEnable) begin
                        Instruction <= {CLEAR_OPCODE, clearIndex, 23'b0};
                        clearIndex  <= clearIndex + 8'd1;
                        if (clearIndex == 8'hFF) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    ClearDone    <= 1'b1;
                    Busy         <= 1'b0;
                    pendingClear <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_instruction_issuer.sv
// tb_gpu_instruction_issuer: directed bench for gpu_instruction_issuer.
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_gpu_instruction_issuer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        CmdValid = 1'b0;
    logic        CmdReady;
    logic [3:0]  CmdOpcode = '0;
    logic [7:0]  CmdSprite = '0;
    logic [22:0] CmdData = '0;
    logic        ClearReq = 1'b0;
    logic        IssueEnable = 1'b0;
    logic [34:0] Instruction;
    logic        Busy;
    logic        ClearDone;
    logic [4:0]  Count;

    int nChecks = 0;
    int nPass   = 0;

    gpu_instruction_issuer #(
        .DEPTH(16),
        .CLEAR_OPCODE(4'hF)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .CmdValid(CmdValid),
        .CmdReady(CmdReady),
        .CmdOpcode(CmdOpcode),
        .CmdSprite(CmdSprite),
        .CmdData(CmdData),
        .ClearReq(ClearReq),
        .IssueEnable(IssueEnable),
        .Instruction(Instruction),
        .Busy(Busy),
        .ClearDone(ClearDone),
        .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic setCmd(input logic v, input logic [3:0] op,
                          input logic [7:0] spr, input logic [22:0] dat);
        CmdValid  = v;
        CmdOpcode = op;
        CmdSprite = spr;
        CmdData   = dat;
    endtask

    function automatic logic [34:0] clearWord(input int idx);
        return {4'hF, 8'(idx), 23'h0};
    endfunction

    initial begin
        // Reset state
        #12;
        check("rst_instr", Instruction, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", ClearDone, 0);
        check("rst_count", Count, 0);
        check("rst_ready", CmdReady, 1);
        @(negedge Clk);
        Reset_n = 1'b1;
        step();

        // 1: single command passes through
        IssueEnable = 1'b1;
        setCmd(1'b1, 4'h1, 8'h05, 23'h000064);
        step();
        setCmd(1'b0, 4'h0, 8'h00, 23'h0);
        check("t1_nop_before", Instruction, 0);
        check("t1_count1", Count, 1);
        step();
        check("t1_instr", Instruction, 35'h0_8280_0064);
        check("t1_count0", Count, 0);
        step();
        check("t1_nop_after", Instruction, 0);

        // 2: fill to DEPTH, hold off, then drain in order
        IssueEnable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            setCmd(1'b1, 4'h2, 8'(i), 23'(i + 100));
            step();
        end
        check("t2_count_full", Count, 16);
        check("t2_ready_full", CmdReady, 0);
        setCmd(1'b1, 4'h3, 8'hEE, 23'h7);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_held", Count, 16);
            check("t2_nop_closed", Instruction, 0);
        end
        setCmd(1'b0, 4'h0, 8'h00, 23'h0);
        IssueEnable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check("t2_drain", Instruction, {4'h2, 8'(i), 23'(i + 100)});
        end
        check("t2_ready_after", CmdReady, 1);
        step();
        check("t2_nop_end", Instruction, 0);
        check("t2_count_end", Count, 0);

        // 3: opcode 0 is dropped
        setCmd(1'b1, 4'h0, 8'h11, 23'h22);
        check("t3_ready", CmdReady, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_count", Count, 0);
            check("t3_nop", Instruction, 0);
        end
        setCmd(1'b0, 4'h0, 8'h00, 23'h0);

        // 4: clear with 3 queued commands; second ClearReq ignored
        IssueEnable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setCmd(1'b1, 4'h4, 8'(10 + i), 23'(i));
            step();
        end
        setCmd(1'b0, 4'h0, 8'h00, 23'h0);
        check("t4_count3", Count, 3);
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        check("t4_busy", Busy, 1);
        IssueEnable = 1'b1;
        step();
        check("t4_entry_nop", Instruction, 0);
        for (int i = 0; i < 256; i++) begin
            ClearReq = (i == 50);
            step();
            check("t4_clear", Instruction, clearWord(i));
        end
        ClearReq = 1'b0;
        check("t4_busy_run", Busy, 1);
        check("t4_count_hold", Count, 3);
        step();
        check("t4_done_nop", Instruction, 0);
        check("t4_done", ClearDone, 1);
        check("t4_busy_off", Busy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_queued", Instruction, {4'h4, 8'(10 + i), 23'(i)});
            check("t4_done_pulse", ClearDone, 0);
        end
        step();
        check("t4_nop_end", Instruction, 0);
        check("t4_count_end", Count, 0);
        check("t4_no_requeue", Busy, 0);

        // 5: issue window closes mid-clear at index 100
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        check("t5_busy", Busy, 1);
        step();
        check("t5_entry_nop", Instruction, 0);
        for (int i = 0; i < 100; i++) begin
            step();
            check("t5_clear_a", Instruction, clearWord(i));
        end
        IssueEnable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t5_pause_nop", Instruction, 0);
        end
        IssueEnable = 1'b1;
        for (int i = 100; i < 256; i++) begin
            step();
            check("t5_clear_b", Instruction, clearWord(i));
        end
        step();
        check("t5_done", ClearDone, 1);
        check("t5_done_nop", Instruction, 0);

        // 6: reset in the middle of a clear
        IssueEnable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            setCmd(1'b1, 4'h5, 8'(i), 23'h55);
            step();
        end
        setCmd(1'b0, 4'h0, 8'h00, 23'h0);
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        IssueEnable = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            step();
        end
        check("t6_pre_count", Count, 2);
        check("t6_pre_instr", Instruction, clearWord(39));
        #2;
        Reset_n = 1'b0;
        #1;
        check("t6_rst_instr", Instruction, 0);
        check("t6_rst_busy", Busy, 0);
        check("t6_rst_count", Count, 0);
        check("t6_rst_ready", CmdReady, 1);
        step();
        step();
        #2;
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_no_done", ClearDone, 0);
            check("t6_idle_nop", Instruction, 0);
        end
        setCmd(1'b1, 4'h7, 8'hAB, 23'h012345);
        step();
        setCmd(1'b0, 4'h0, 8'h00, 23'h0);
        step();
        check("t6_after_rst", Instruction, 35'h3_D581_2345);
        step();
        check("t6_nop_end", Instruction, 0);
        check("t6_busy_end", Busy, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
